// File: rtl/riscv_control_pkg.sv
// riscv_control_pkg: shared RISC-V control constants for the multi-cycle controller and the ALU controller.
// Contents: opcode constants, multi-cycle state encodings, ALUOp codes, ALUSrcB select codes
// and a legality check for the opcodes the multi-cycle datapath supports.
package riscv_control_pkg;

    localparam logic [6:0] R_FORMAT = 7'b0110011;
    localparam logic [6:0] LD       = 7'b0000011;
    localparam logic [6:0] SD       = 7'b0100011;
    localparam logic [6:0] BEQ      = 7'b1100011;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEMORY    = 3'd3,
        WRITEBACK = 3'd4,
        HALT      = 3'd5
    } state_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RS2    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    function automatic logic is_legal(input logic [6:0] opcode);
        return opcode == R_FORMAT || opcode == LD || opcode == SD || opcode == BEQ;
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: control bus between the multi-cycle controller and the datapath.
// Datapath -> controller: opcode, zero, memoryReady.
// Controller -> datapath: PC/IR/register/memory strobes, mux selects and ALUOp.
// Modports: master = controller, slave = datapath.
interface multicycle_controller_if;

    logic [6:0] opcode;
    logic       zero;
    logic       memoryReady;
    logic       pcWrite;
    logic       irWrite;
    logic       instructionOrData;
    logic       memoryRead;
    logic       memoryWrite;
    logic       rWrite;
    logic       memoryToRegister;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic       pcSource;

    modport master (
        input  opcode, zero, memoryReady,
        output pcWrite, irWrite, instructionOrData, memoryRead, memoryWrite, rWrite,
               memoryToRegister, ALUSrcA, ALUSrcB, ALUOp, pcSource
    );

    modport slave (
        output opcode, zero, memoryReady,
        input  pcWrite, irWrite, instructionOrData, memoryRead, memoryWrite, rWrite,
               memoryToRegister, ALUSrcA, ALUSrcB, ALUOp, pcSource
    );

endinterface

// File: rtl/instruction_counter.sv
// instruction_counter: retired-instruction counter, wraps silently from all-ones to zero.
// Ports: clock, reset (sync, active-high, priority over enable), enable (one pulse per
// retired instruction), count (current total).
module instruction_counter #(
    parameter int COUNTER_WIDTH = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    output logic [COUNTER_WIDTH-1:0] count
);

    always_ff @(posedge clock)
        count <= reset ? '0 : enable ? count + 1'b1 : count;

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: multi-cycle sequencing FSM for R-format, LD, SD and BEQ.
// Ports: clock, reset (sync, active-high), bus (master side of the control bus:
// opcode/zero/memoryReady in, strobes and mux selects out), retired (one-cycle pulse per
// completed instruction), instructionCount, illegalInstruction (sticky), state (debug).
module multicycle_controller
    import riscv_control_pkg::*;
#(
    parameter int COUNTER_WIDTH = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    multicycle_controller_if.master   bus,
    output logic                      retired,
    output logic [COUNTER_WIDTH-1:0]  instructionCount,
    output logic                      illegalInstruction,
    output logic [2:0]                state
);

    state_t     currentState, nextState;
    logic [6:0] opcodeLatch;
    logic       isR, isLd, isSd, isBeq;

    // Execute and later states decode only the opcode captured in DECODE, so the IR
    // input is free to change once decode is done.
    assign isR   = opcodeLatch == R_FORMAT;
    assign isLd  = opcodeLatch == LD;
    assign isSd  = opcodeLatch == SD;
    assign isBeq = opcodeLatch == BEQ;
    assign state = currentState;

    always_ff @(posedge clock) begin
        if (reset) begin
            currentState       <= FETCH;
            opcodeLatch        <= '0;
            illegalInstruction <= 1'b0;
        end else begin
            currentState <= nextState;
            if (currentState == DECODE)
                opcodeLatch <= bus.opcode;
            if (currentState == DECODE && !is_legal(bus.opcode))
                illegalInstruction <= 1'b1;
        end
    end

    always_comb begin
        nextState = HALT;
        case (currentState)
            FETCH:     nextState = bus.memoryReady ? DECODE : FETCH;
            DECODE:    nextState = is_legal(bus.opcode) ? EXECUTE : HALT;
            EXECUTE:   nextState = isR ? WRITEBACK : (isLd || isSd) ? MEMORY : FETCH;
            MEMORY:    nextState = !bus.memoryReady ? MEMORY : isLd ? WRITEBACK : FETCH;
            WRITEBACK: nextState = FETCH;
            HALT:      nextState = HALT;
            default:   nextState = HALT;
        endcase
    end

    // All strobes are held low while reset is asserted so an abandoned instruction
    // never writes in the reset cycle.
    always_comb begin
        bus.pcWrite           = 1'b0;
        bus.irWrite           = 1'b0;
        bus.instructionOrData = 1'b0;
        bus.memoryRead        = 1'b0;
        bus.memoryWrite       = 1'b0;
        bus.rWrite            = 1'b0;
        bus.memoryToRegister  = 1'b0;
        bus.ALUSrcA           = 1'b0;
        bus.ALUSrcB           = SRCB_RS2;
        bus.ALUOp             = ALU_ADD;
        bus.pcSource          = 1'b0;
        retired               = 1'b0;
        if (!reset) begin
            case (currentState)
                FETCH: begin
                    bus.memoryRead = 1'b1;
                    bus.irWrite    = bus.memoryReady;
                    bus.pcWrite    = bus.memoryReady;
                    bus.ALUSrcB    = bus.memoryReady ? SRCB_FOUR : SRCB_RS2;
                end
                DECODE: bus.ALUSrcB = SRCB_BRANCH;
                EXECUTE: begin
                    bus.ALUSrcA  = 1'b1;
                    bus.ALUSrcB  = (isLd || isSd) ? SRCB_IMM : SRCB_RS2;
                    bus.ALUOp    = isR ? ALU_FUNCT : isBeq ? ALU_SUB : ALU_ADD;
                    bus.pcSource = isBeq;
                    bus.pcWrite  = isBeq && bus.zero;
                    retired      = isBeq;
                end
                MEMORY: begin
                    bus.instructionOrData = 1'b1;
                    bus.memoryRead        = isLd;
                    bus.memoryWrite       = isSd;
                    retired               = isSd && bus.memoryReady;
                end
                WRITEBACK: begin
                    bus.rWrite           = 1'b1;
                    bus.memoryToRegister = isLd;
                    retired              = 1'b1;
                end
                default: ;
            endcase
        end
    end

    instruction_counter #(
        .COUNTER_WIDTH(COUNTER_WIDTH)
    ) u_counter (
        .clock  (clock),
        .reset  (reset),
        .enable (retired),
        .count  (instructionCount)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: scoreboard bench for the multi-cycle controller (4-bit counter).
module tb_multicycle_controller;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_SD  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    // {pcWrite, irWrite, instructionOrData, memoryRead, memoryWrite, rWrite,
    //  memoryToRegister, ALUSrcA, ALUSrcB[1:0], ALUOp[1:0], pcSource, retired}
    localparam logic [13:0] NONE  = 14'h0000;
    localparam logic [13:0] F_W   = 14'h0400;
    localparam logic [13:0] F_R   = 14'h3410;
    localparam logic [13:0] DEC   = 14'h0030;
    localparam logic [13:0] EX_R  = 14'h0048;
    localparam logic [13:0] EX_M  = 14'h0060;
    localparam logic [13:0] EX_B1 = 14'h2047;
    localparam logic [13:0] EX_B0 = 14'h0047;
    localparam logic [13:0] M_LD  = 14'h0C00;
    localparam logic [13:0] M_SD  = 14'h0A00;
    localparam logic [13:0] M_SDR = 14'h0A01;
    localparam logic [13:0] WB_LD = 14'h0181;
    localparam logic [13:0] WB_R  = 14'h0101;

    typedef struct packed {
        logic [2:0]  st;
        logic [13:0] ctrl;
        logic [3:0]  cnt;
        logic        ill;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       retired;
    logic [3:0] instructionCount;
    logic       illegalInstruction;
    logic [2:0] state;
    exp_t       q[$];
    int         errors = 0;
    int         checks = 0;
    int         ncyc = 0;

    multicycle_controller_if bus();

    multicycle_controller #(.COUNTER_WIDTH(4)) dut (
        .clock              (clock),
        .reset              (reset),
        .bus                (bus.master),
        .retired            (retired),
        .instructionCount   (instructionCount),
        .illegalInstruction (illegalInstruction),
        .state              (state)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [13:0] got, input logic [13:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, ncyc, got, want);
        end
    endtask

    always @(negedge clock) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            ncyc++;
            check("ctrl", {bus.pcWrite, bus.irWrite, bus.instructionOrData, bus.memoryRead,
                           bus.memoryWrite, bus.rWrite, bus.memoryToRegister, bus.ALUSrcA,
                           bus.ALUSrcB, bus.ALUOp, bus.pcSource, retired}, e.ctrl);
            check("state", 14'(state), 14'(e.st));
            check("count", 14'(instructionCount), 14'(e.cnt));
            check("illegal", 14'(illegalInstruction), 14'(e.ill));
        end
    end

    task automatic cyc(input logic r, input logic [6:0] op, input logic z, input logic rdy,
                       input logic [2:0] st, input logic [13:0] ctrl, input logic [3:0] cnt,
                       input logic ill);
        @(posedge clock);
        #1;
        reset           = r;
        bus.opcode      = op;
        bus.zero        = z;
        bus.memoryReady = rdy;
        q.push_back('{st: st, ctrl: ctrl, cnt: cnt, ill: ill});
    endtask

    initial begin
        reset = 1'b1;
        bus.opcode = '0;
        bus.zero = 1'b0;
        bus.memoryReady = 1'b0;
        cyc(1, 0, 0, 0, 0, NONE, 0, 0);
        cyc(1, 0, 1, 1, 0, NONE, 0, 0);
        // R-format, zero wait
        cyc(0, 0,    0, 1, 0, F_R,  0, 0);
        cyc(0, OP_R, 0, 1, 1, DEC,  0, 0);
        cyc(0, 0,    0, 1, 2, EX_R, 0, 0);
        cyc(0, 0,    0, 1, 4, WB_R, 0, 0);
        // LD: 2 fetch waits, 3 memory waits
        cyc(0, 0,     0, 0, 0, F_W,   1, 0);
        cyc(0, 0,     0, 0, 0, F_W,   1, 0);
        cyc(0, 0,     0, 1, 0, F_R,   1, 0);
        cyc(0, OP_LD, 0, 0, 1, DEC,   1, 0);
        cyc(0, 0,     0, 0, 2, EX_M,  1, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 3, M_LD, 1, 0);
        cyc(0, 0,     0, 1, 3, M_LD,  1, 0);
        cyc(0, 0,     0, 0, 4, WB_LD, 1, 0);
        // SD zero wait
        cyc(0, 0,     0, 1, 0, F_R,   2, 0);
        cyc(0, OP_SD, 0, 1, 1, DEC,   2, 0);
        cyc(0, 0,     0, 1, 2, EX_M,  2, 0);
        cyc(0, 0,     0, 1, 3, M_SDR, 2, 0);
        // BEQ taken, then not taken; opcode input changed after decode
        cyc(0, 0,      0, 1, 0, F_R,   3, 0);
        cyc(0, OP_BEQ, 0, 1, 1, DEC,   3, 0);
        cyc(0, OP_R,   1, 1, 2, EX_B1, 3, 0);
        cyc(0, 0,      1, 1, 0, F_R,   4, 0);
        cyc(0, OP_BEQ, 1, 0, 1, DEC,   4, 0);
        cyc(0, OP_LD,  0, 0, 2, EX_B0, 4, 0);
        // run BEQs through the 4-bit wrap: 5..15, 0, landing on 1
        for (int i = 0; i < 12; i++) begin
            logic [3:0] c;
            c = 4'(5 + i);
            cyc(0, 0,      0, 1, 0, F_R,   c, 0);
            cyc(0, OP_BEQ, 0, 1, 1, DEC,   c, 0);
            cyc(0, 0,      1, 1, 2, EX_B1, c, 0);
        end
        // reset during SD MEMORY wait
        cyc(0, 0,     0, 1, 0, F_R,  1, 0);
        cyc(0, OP_SD, 0, 1, 1, DEC,  1, 0);
        cyc(0, 0,     0, 1, 2, EX_M, 1, 0);
        cyc(0, 0,     0, 0, 3, M_SD, 1, 0);
        cyc(1, 0,     0, 0, 3, NONE, 1, 0);
        cyc(0, 0,     0, 0, 0, F_W,  0, 0);
        // illegal opcode traps into HALT
        cyc(0, 0,      0, 1, 0, F_R, 0, 0);
        cyc(0, OP_BAD, 0, 1, 1, DEC, 0, 0);
        for (int i = 0; i < 20; i++) cyc(0, OP_SD, i[0], i[1], 5, NONE, 0, 1);
        cyc(1, 0, 0, 1, 5, NONE, 0, 1);
        cyc(0, 0, 0, 0, 0, F_W,  0, 0);
        repeat (3) @(posedge clock);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle sequencing FSM for the RISC-V datapath; replaces single-cycle opcode decode with per-state control strobes.
- Supports R-format (0110011), LD (0000011), SD (0100011) and BEQ (1100011) over a shared instruction/data memory with a ready handshake.
- Drives PC, IR, register file, memory and ALU-source muxes, and emits ALUOp to the existing ALU controller.
- Counts retired instructions and traps illegal opcodes.

Parameters:
- COUNTER_WIDTH, 32: width of the retired-instruction counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  7  instruction[6:0] from the IR; valid from DECODE onward.
- zero  in  1  ALU zero flag, used by BEQ in EXECUTE.
- memoryReady  in  1  memory completes the current read/write this cycle.
- pcWrite  out  1  PC load enable, already qualified by branch/zero.
- irWrite  out  1  IR load enable.
- instructionOrData  out  1  memory address mux: 0 = PC, 1 = ALUOut.
- memoryRead  out  1  memory read request.
- memoryWrite  out  1  memory write request.
- rWrite  out  1  register file write enable.
- memoryToRegister  out  1  write-back mux: 0 = ALUOut, 1 = MDR.
- ALUSrcA  out  1  ALU A mux: 0 = PC, 1 = rs1.
- ALUSrcB  out  2  ALU B mux: 00 = rs2, 01 = constant 4, 10 = immediate, 11 = branch offset.
- ALUOp  out  2  00 = add, 01 = subtract/compare, 10 = funct-decoded.
- pcSource  out  1  PC mux: 0 = ALU result, 1 = ALUOut (branch target).
- retired  out  1  one-cycle pulse when an instruction completes.
- instructionCount  out  COUNTER_WIDTH  retired-instruction count.
- illegalInstruction  out  1  sticky trap flag.
- state  out  3  current state, for debug.

Behaviour:
- States and encodings: FETCH = 0, DECODE = 1, EXECUTE = 2, MEMORY = 3, WRITEBACK = 4, HALT = 5. Encodings 6 and 7 go to HALT.
- Default for every output not listed in a state is 0.
- Reset:
  - While reset is high, every control output is forced to 0.
  - The next edge loads state = FETCH, instructionCount = 0, illegalInstruction = 0 and the opcode latch = 0.
  - Reset mid-operation abandons the instruction with no write strobe in the reset cycle.
- FETCH:
  - memoryRead = 1, instructionOrData = 0.
  - Holds while memoryReady = 0, with no other strobe asserted.
  - When memoryReady = 1, in the same cycle: irWrite = 1, pcWrite = 1, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, pcSource = 0. Next state is DECODE.
- DECODE:
  - ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00 (branch target into ALUOut).
  - opcode is latched internally; later states decode only the latch.
  - Legal opcode goes to EXECUTE. Any other opcode goes to HALT and sets illegalInstruction.
- EXECUTE:
  - R-format: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10; next WRITEBACK.
  - LD/SD: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00; next MEMORY.
  - BEQ: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, pcSource = 1, pcWrite = zero, retired = 1; next FETCH.
- MEMORY:
  - instructionOrData = 1; memoryRead = 1 for LD, memoryWrite = 1 for SD.
  - The request is held stable until memoryReady = 1.
  - On ready, LD goes to WRITEBACK; SD asserts retired = 1 and goes to FETCH.
- WRITEBACK:
  - rWrite = 1, memoryToRegister = 1 for LD and 0 for R-format, retired = 1; next FETCH.
- HALT:
  - All strobes are 0; exits only via reset.
  - Memory requests and memoryReady are ignored.
- Latency with zero-wait memory (memoryReady always 1):
  - BEQ 3 cycles, R-format 4, SD 4, LD 5.
  - Each memory wait cycle adds 1.
- Handshake rules:
  - memoryRead and memoryWrite are never high together.
  - memoryReady seen outside FETCH/MEMORY is ignored.
- Counter:
  - instructionCount increments on the edge after each retired pulse.
  - Wraps from all-ones to 0 without a flag.
  - Reset has priority over increment.

Decomposition:
- Shared package riscv_control_pkg holds:
  - opcode constants R_FORMAT, LD, SD, BEQ;
  - state encodings;
  - ALUOp codes;
  - ALUSrcB select codes.
- The existing single-cycle controller is updated to import the same opcode and ALUOp constants.
- One sub-module, instruction_counter: enable = retired, parameter COUNTER_WIDTH, synchronous reset.

Test Plan:
- Zero-wait R-format (opcode 0110011): state sequence 0,1,2,4,0. rWrite high only in the WRITEBACK cycle; retired pulses once; instructionCount becomes 1.
- LD with memoryReady low for 2 cycles in FETCH and 3 in MEMORY: total 10 cycles. memoryRead and instructionOrData are stable while waiting; memoryToRegister = 1 and rWrite = 1 in WRITEBACK.
- SD, then BEQ with zero = 1, then BEQ with zero = 0:
  - memoryWrite is asserted only in the SD MEMORY state, and rWrite is never asserted.
  - pcWrite = 1 and pcSource = 1 in the first BEQ EXECUTE; pcWrite = 0 in the second.
  - instructionCount = 3.
- Illegal opcode 1111111 in DECODE: next state is HALT (5) and illegalInstruction = 1. Outputs stay 0 for 20 cycles regardless of memoryReady; reset then returns to FETCH with the flag cleared.
- Reset asserted during SD MEMORY while memoryReady = 0: memoryWrite drops in the reset cycle and FETCH follows after release. Count is 0, and memoryRead = 1 on the first post-reset cycle.
- Counter preloaded near wrap (force instructionCount to all-ones, COUNTER_WIDTH = 4): the next retired pulse gives 0, and no other output is disturbed.
